// File: rtl/flop_pkg.sv
// Shared definitions for the sign/exponent/mantissa "flop" number format.
// Layout is {sign, exp, man}; field helpers take the value zero-extended to 32 bits.
package flop_pkg;

  localparam int EXP_W_DEF = 4;
  localparam int MAN_W_DEF = 8;

  localparam logic [2:0] MODE_GT  = 3'd0;
  localparam logic [2:0] MODE_LT  = 3'd1;
  localparam logic [2:0] MODE_EQ  = 3'd2;
  localparam logic [2:0] MODE_MAX = 3'd3;
  localparam logic [2:0] MODE_MIN = 3'd4;

  function automatic logic flop_sign(input logic [31:0] x, input int exp_w, input int man_w);
    logic [31:0] t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [31:0] flop_exp(input logic [31:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & ((32'd1 << exp_w) - 32'd1);
  endfunction

  function automatic logic [31:0] flop_man(input logic [31:0] x, input int man_w);
    return x & ((32'd1 << man_w) - 32'd1);
  endfunction

endpackage

// File: rtl/flop_order_cmp.sv
// Resolves signed order of two flop values from their pre-computed sign, zero and
// magnitude-compare terms. +0 and -0 compare equal.
module flop_order_cmp (
  input  logic sign_a,
  input  logic sign_b,
  input  logic zero_a,
  input  logic zero_b,
  input  logic mag_gt,
  input  logic mag_eq,
  output logic a_gt_b,
  output logic a_eq_b
);

  always_comb begin
    a_eq_b = (zero_a && zero_b) || ((sign_a == sign_b) && mag_eq);
    if (a_eq_b)
      a_gt_b = 1'b0;
    else if (sign_a != sign_b)
      a_gt_b = !sign_a;
    else if (!sign_a)
      a_gt_b = mag_gt;
    else
      a_gt_b = !mag_gt;  // both negative and unequal: smaller magnitude is greater
  end

endmodule

// File: rtl/flop_compare_pipe.sv
// Two-stage pipelined flop comparator with GT/LT/EQ/MAX/MIN modes, valid/ready
// flow control and a running max/min accumulator on the output side.
module flop_compare_pipe
  import flop_pkg::*;
#(
  parameter  int EXP_W  = EXP_W_DEF,
  parameter  int MAN_W  = MAN_W_DEF,
  localparam int FLOP_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLOP_W-1:0] first,
  input  logic [FLOP_W-1:0] second,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_flag,
  output logic [FLOP_W-1:0] out_value,
  input  logic              acc_clear,
  output logic [FLOP_W-1:0] acc_value,
  output logic              acc_valid
);

  logic              vld_p1_q;
  logic [2:0]        mode_p1_q;
  logic [FLOP_W-1:0] a_p1_q, b_p1_q;
  logic              sa_p1_q, sb_p1_q, za_p1_q, zb_p1_q, mgt_p1_q, meq_p1_q;

  logic              vld_p2_q, flag_p2_q, flag_p2_d;
  logic [2:0]        mode_p2_q;
  logic [FLOP_W-1:0] value_p2_q, value_p2_d;

  logic              acc_vld_q, acc_vld_d;
  logic [FLOP_W-1:0] acc_value_q, acc_value_d;

  logic s2_free, gt_p2, eq_p2, acc_gt, acc_eq;

  assign s2_free  = !vld_p2_q || out_ready;
  assign in_ready = s2_free || !vld_p1_q;

  // S1: capture operands, mode and per-operand pre-compare terms
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      mode_p1_q <= mode;
      a_p1_q    <= first;
      b_p1_q    <= second;
      sa_p1_q   <= flop_sign(32'(first), EXP_W, MAN_W);
      sb_p1_q   <= flop_sign(32'(second), EXP_W, MAN_W);
      za_p1_q   <= (flop_exp(32'(first), EXP_W, MAN_W) == 32'd0) && (flop_man(32'(first), MAN_W) == 32'd0);
      zb_p1_q   <= (flop_exp(32'(second), EXP_W, MAN_W) == 32'd0) && (flop_man(32'(second), MAN_W) == 32'd0);
      mgt_p1_q  <= first[FLOP_W-2:0] > second[FLOP_W-2:0];
      meq_p1_q  <= first[FLOP_W-2:0] == second[FLOP_W-2:0];
    end
  end

  flop_order_cmp u_cmp_p2 (
    .sign_a (sa_p1_q),
    .sign_b (sb_p1_q),
    .zero_a (za_p1_q),
    .zero_b (zb_p1_q),
    .mag_gt (mgt_p1_q),
    .mag_eq (meq_p1_q),
    .a_gt_b (gt_p2),
    .a_eq_b (eq_p2)
  );

  // S2: resolve order and apply mode
  always_comb begin
    flag_p2_d  = gt_p2;
    value_p2_d = a_p1_q;
    case (mode_p1_q)
      MODE_LT:  flag_p2_d = !gt_p2 && !eq_p2;
      MODE_EQ:  flag_p2_d = eq_p2;
      MODE_MAX: begin
        flag_p2_d  = gt_p2 || eq_p2;
        value_p2_d = flag_p2_d ? a_p1_q : b_p1_q;
      end
      MODE_MIN: begin
        flag_p2_d  = !gt_p2;
        value_p2_d = flag_p2_d ? a_p1_q : b_p1_q;
      end
      default:  flag_p2_d = gt_p2;
    endcase
  end

  flop_order_cmp u_cmp_acc (
    .sign_a (flop_sign(32'(value_p2_q), EXP_W, MAN_W)),
    .sign_b (flop_sign(32'(acc_value_q), EXP_W, MAN_W)),
    .zero_a (value_p2_q[FLOP_W-2:0] == '0),
    .zero_b (acc_value_q[FLOP_W-2:0] == '0),
    .mag_gt (value_p2_q[FLOP_W-2:0] > acc_value_q[FLOP_W-2:0]),
    .mag_eq (value_p2_q[FLOP_W-2:0] == acc_value_q[FLOP_W-2:0]),
    .a_gt_b (acc_gt),
    .a_eq_b (acc_eq)
  );

  always_comb begin
    acc_vld_d   = acc_vld_q;
    acc_value_d = acc_value_q;
    if (acc_clear) begin
      acc_vld_d   = 1'b0;
      acc_value_d = '0;
    end else if (vld_p2_q && out_ready && (mode_p2_q == MODE_MAX || mode_p2_q == MODE_MIN)) begin
      if (!acc_vld_q ||
          ((mode_p2_q == MODE_MAX) ? acc_gt : (!acc_gt && !acc_eq))) begin
        acc_vld_d   = 1'b1;
        acc_value_d = value_p2_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      flag_p2_q   <= 1'b0;
      mode_p2_q   <= MODE_GT;
      value_p2_q  <= '0;
      acc_vld_q   <= 1'b0;
      acc_value_q <= '0;
    end else begin
      if (in_ready)
        vld_p1_q <= in_valid;
      if (s2_free) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          flag_p2_q  <= flag_p2_d;
          mode_p2_q  <= mode_p1_q;
          value_p2_q <= value_p2_d;
        end
      end
      acc_vld_q   <= acc_vld_d;
      acc_value_q <= acc_value_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_flag  = flag_p2_q;
  assign out_value = value_p2_q;
  assign acc_valid = acc_vld_q;
  assign acc_value = acc_value_q;

endmodule

// File: tb/tb_flop_compare_pipe.sv
// Directed testbench for flop_compare_pipe with EXP_W=4, MAN_W=8.
module tb_flop_compare_pipe;
  import flop_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [12:0] first, second;
  logic [2:0]  mode;
  logic        out_valid, out_ready, out_flag;
  logic [12:0] out_value;
  logic        acc_clear, acc_valid;
  logic [12:0] acc_value;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  flop_compare_pipe #(.EXP_W(4), .MAN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .first     (first),
    .second    (second),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flag  (out_flag),
    .out_value (out_value),
    .acc_clear (acc_clear),
    .acc_value (acc_value),
    .acc_valid (acc_valid)
  );

  task automatic run_op(input logic [12:0] a, input logic [12:0] b, input logic [2:0] m,
                        output logic vld, output logic flag, output logic [12:0] val);
    @(negedge clk);
    first = a; second = b; mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vld = out_valid; flag = out_flag; val = out_value;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; first = '0; second = '0; mode = MODE_GT;
    out_ready = 1'b1; acc_clear = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (out_flag !== 1'b0) $display("FAIL reset_out_flag got=%0b exp=0", out_flag); else passed++;
    total++; if (out_value !== 13'h0) $display("FAIL reset_out_value got=%h exp=0000", out_value); else passed++;
    total++; if (acc_valid !== 1'b0) $display("FAIL reset_acc_valid got=%0b exp=0", acc_valid); else passed++;
    total++; if (acc_value !== 13'h0) $display("FAIL reset_acc_value got=%h exp=0000", acc_value); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else passed++;
  endtask

  task automatic test_gt_eq();
    logic v, f; logic [12:0] r;
    run_op(13'h1801, 13'h1801, MODE_GT, v, f, r);
    total++; if (v !== 1'b1) $display("FAIL gt_same_valid got=%0b exp=1", v); else passed++;
    total++; if (f !== 1'b0) $display("FAIL gt_same_flag got=%0b exp=0", f); else passed++;
    total++; if (r !== 13'h1801) $display("FAIL gt_same_value got=%h exp=1801", r); else passed++;
    run_op(13'h1801, 13'h1801, MODE_EQ, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL eq_same_flag got=%0b exp=1", f); else passed++;
  endtask

  task automatic test_zero();
    logic v, f; logic [12:0] r;
    run_op(13'h0000, 13'h1000, MODE_EQ, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL zero_eq_flag got=%0b exp=1", f); else passed++;
    run_op(13'h0000, 13'h1000, MODE_GT, v, f, r);
    total++; if (f !== 1'b0) $display("FAIL zero_gt_flag got=%0b exp=0", f); else passed++;
    run_op(13'h1000, 13'h0000, MODE_LT, v, f, r);
    total++; if (f !== 1'b0) $display("FAIL zero_lt_flag got=%0b exp=0", f); else passed++;
  endtask

  task automatic test_sign_order();
    logic v, f; logic [12:0] r;
    run_op(13'h1802, 13'h1801, MODE_GT, v, f, r);
    total++; if (f !== 1'b0) $display("FAIL neg_gt_flag got=%0b exp=0", f); else passed++;
    run_op(13'h1802, 13'h1801, MODE_LT, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL neg_lt_flag got=%0b exp=1", f); else passed++;
    run_op(13'h0001, 13'h1FFF, MODE_GT, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL sign_gt_flag got=%0b exp=1", f); else passed++;
    run_op(13'h0001, 13'h1FFF, 3'd7, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL mode7_gt_flag got=%0b exp=1", f); else passed++;
    run_op(13'h1802, 13'h1801, MODE_MAX, v, f, r);
    total++; if (f !== 1'b0) $display("FAIL max_flag got=%0b exp=0", f); else passed++;
    total++; if (r !== 13'h1801) $display("FAIL max_value got=%h exp=1801", r); else passed++;
    run_op(13'h1802, 13'h1801, MODE_MIN, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL min_flag got=%0b exp=1", f); else passed++;
    total++; if (r !== 13'h1802) $display("FAIL min_value got=%h exp=1802", r); else passed++;
    run_op(13'h0F00, 13'h0EFF, MODE_GT, v, f, r);
    total++; if (f !== 1'b1) $display("FAIL allones_exp_gt got=%0b exp=1", f); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [12:0] pa [4];
    logic [12:0] pb [4];
    logic        ef [4];
    int in_idx, out_idx;
    bit stalled;
    pa = '{13'h0101, 13'h0102, 13'h1103, 13'h0004};
    pb = '{13'h0100, 13'h0200, 13'h1200, 13'h1004};
    ef = '{1'b1, 1'b0, 1'b1, 1'b1};
    in_idx = 0; out_idx = 0; stalled = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      if (in_idx < 4) begin
        in_valid = 1'b1; first = pa[in_idx]; second = pb[in_idx]; mode = MODE_GT;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) stalled = 1'b1;
      if (out_valid && out_ready) begin
        if (out_idx < 4) begin
          total++; if (out_flag !== ef[out_idx]) $display("FAIL b2b_flag[%0d] got=%0b exp=%0b", out_idx, out_flag, ef[out_idx]); else passed++;
          total++; if (out_value !== pa[out_idx]) $display("FAIL b2b_value[%0d] got=%h exp=%h", out_idx, out_value, pa[out_idx]); else passed++;
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_idx != 4) $display("FAIL b2b_count got=%0d exp=4", out_idx); else passed++;
    total++; if (stalled !== 1'b1) $display("FAIL b2b_in_ready_drop got=%0b exp=1", stalled); else passed++;
  endtask

  task automatic test_accumulator();
    logic v, f; logic [12:0] r;
    logic [12:0] mx [4];
    logic [12:0] mxe [4];
    logic [12:0] mn [3];
    logic [12:0] mne [3];
    mx  = '{13'h0100, 13'h1300, 13'h0200, 13'h0200};
    mxe = '{13'h0100, 13'h0100, 13'h0200, 13'h0200};
    mn  = '{13'h0200, 13'h1100, 13'h0100};
    mne = '{13'h0200, 13'h1100, 13'h1100};
    @(negedge clk); acc_clear = 1'b1;
    @(negedge clk); acc_clear = 1'b0;
    total++; if (acc_valid !== 1'b0) $display("FAIL acc_clear_valid got=%0b exp=0", acc_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      run_op(mx[i], mx[i], MODE_MAX, v, f, r);
      total++; if (f !== 1'b1) $display("FAIL acc_max_tie_flag[%0d] got=%0b exp=1", i, f); else passed++;
      acc_clear = (i == 3);
      @(negedge clk);
      acc_clear = 1'b0;
      if (i < 3) begin
        total++; if (acc_valid !== 1'b1) $display("FAIL acc_max_valid[%0d] got=%0b exp=1", i, acc_valid); else passed++;
        total++; if (acc_value !== mxe[i]) $display("FAIL acc_max_value[%0d] got=%h exp=%h", i, acc_value, mxe[i]); else passed++;
      end else begin
        total++; if (acc_valid !== 1'b0) $display("FAIL acc_clear_prio_valid got=%0b exp=0", acc_valid); else passed++;
        total++; if (acc_value !== 13'h0) $display("FAIL acc_clear_prio_value got=%h exp=0000", acc_value); else passed++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_op(mn[i], mn[i], MODE_MIN, v, f, r);
      @(negedge clk);
      total++; if (acc_value !== mne[i]) $display("FAIL acc_min_value[%0d] got=%h exp=%h", i, acc_value, mne[i]); else passed++;
    end
    run_op(13'h1F00, 13'h0000, MODE_GT, v, f, r);
    @(negedge clk);
    total++; if (acc_value !== 13'h1100) $display("FAIL acc_gt_untouched got=%h exp=1100", acc_value); else passed++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(negedge clk);
    first = 13'h0005; second = 13'h0003; mode = MODE_GT; in_valid = 1'b1;
    @(negedge clk);
    first = 13'h0007; second = 13'h0009;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid got=%0b exp=1", out_valid); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (acc_valid !== 1'b0) $display("FAIL midrst_acc_valid got=%0b exp=0", acc_valid); else passed++;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) $display("FAIL midrst_emitted got=%0d exp=0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_gt_eq();
    test_zero();
    test_sign_order();
    test_back_to_back();
    test_accumulator();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
